currctrl_debug_capture: RTL and testbench
=========================================

# currctrl_debug_capture

Trace-capture writer for the current-control debug RAM. It takes sample words from the current-control loop and decimates them. It writes them into the RAM's second port (address2/writedata2/byteenable2/chipselect2/write2/clken2) as a circular pre/post-trigger buffer, then freezes and reports where the capture starts so the CPU can read it through the first port.

## Interface
- DEPTH, 512: buffer words; must equal the RAM depth (power of two).
- ADDR_W, 9: log2(DEPTH).
- DATA_W, 32: sample and RAM word width.
- clk  in  1  capture clock (same clock as RAM port 2)
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  start capture pulse; honoured only in IDLE or DONE
- abort  in  1  return to IDLE, no done/irq
- pre_count  in  ADDR_W  pre-trigger samples, latched at arm (0..DEPTH-1)
- decim  in  8  keep every (decim+1)th valid sample, latched at arm
- trigger  in  1  trigger request, level-sampled each cycle
- sample_valid  in  1  sample_data qualifier
- sample_data  in  DATA_W  sample word from control loop
- address2  out  ADDR_W  RAM write address
- writedata2  out  DATA_W  RAM write data
- byteenable2  out  4  constant 4'hF
- chipselect2, write2  out  1 each  identical one-cycle write strobe
- clken2  out  1  constant 1
- busy  out  1  state not IDLE/DONE
- done  out  1  level, high in DONE
- irq  out  1  one-cycle pulse on entry to DONE
- start_addr  out  ADDR_W  address of oldest captured sample, valid while done

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Reset: state IDLE; wr_ptr, decimation counter, post counter, all outputs 0 except byteenable2=4'hF and clken2=1.
- Accepted sample: sample_valid high and the decimation counter = 0. The counter counts 0..decim on each valid sample, reloaded to 0 at arm. The first valid sample after arm is accepted.
- arm (IDLE/DONE): latch pre_count and decim; wr_ptr<=0. Go to PRE, or to ARMED if pre_count=0.
- PRE: write accepted samples at wr_ptr, wr_ptr++. After pre_count writes, go to ARMED. trigger is ignored in PRE.
- ARMED: write accepted samples, wr_ptr wraps modulo DEPTH. On trigger high: trig_addr<=wr_ptr after any same-cycle write. A sample accepted in the trigger cycle counts as pre-trigger. post_cnt<=DEPTH-pre_count. Go to POST.
- POST: write accepted samples and decrement post_cnt. The write that takes post_cnt to 0 moves the block to DONE. start_addr<=(trig_addr-pre_count) mod DEPTH.
- DONE: no writes (buffer frozen), done=1. arm restarts; pre-trigger data is overwritten.
- abort in any state: go to IDLE next cycle and suppress any write in that cycle.
- arm is ignored in PRE, ARMED and POST. abort has priority over arm and over trigger.

## Timing
- A sample accepted at cycle t appears on address2/writedata2 with write2=1 at t+1. All outputs are registered.
- Maximum rate is one write per clock (decim=0).
- irq rises in the cycle after the final POST write is issued, together with done. start_addr is stable from that cycle.
- Trigger-to-first-post-sample latency: the next accepted sample after the trigger cycle.
- reset_n deassertion mid-capture: the block returns to IDLE and RAM contents are left as-is.

## Configuration
- CURRCTRL_DBG_TIMESTAMP_EN defined: writedata2[31:24] is replaced by an 8-bit counter that increments on each accepted sample. The counter is cleared at arm and wraps 255->0. Bits [23:0] come from sample_data.
- Macro undefined: writedata2 = sample_data unchanged. No counter is instantiated.

## Structure
- Shared package currctrl_dbg_pkg holds:
  - the state enum;
  - DBG_DEPTH=512 and DBG_ADDR_W=9;
  - DBG_TS_W=8.
- One sub-module, currctrl_dbg_decimator: decimation counter plus the accept strobe. Everything else (FSM and write pointer) stays in the top module.

## Test plan
- pre_count=0, decim=0, arm, trigger in cycle 5, continuous valid samples 0..: exactly 512 writes at addresses 0..511 with data 0..511; irq pulse once; start_addr=0.
- pre_count=100, decim=0, trigger held high from arm: trigger is ignored until 100 writes are done, then fires. start_addr=0, trig_addr=100, 512 writes total.
- pre_count=100, trigger after 700 accepted samples (wraps): trig_addr=700 mod 512=188; start_addr=88. POST writes 412 samples, last at address 87.
- decim=3, valid every cycle: writes carry samples 0,4,8,...; write2 is high one cycle in four.
- abort during POST: busy drops next cycle with no further writes and no irq. A later arm restarts at address 0.
- With CURRCTRL_DBG_TIMESTAMP_EN, sample_data=32'hFFFFFFFF: writedata2 reads 32'h00FFFFFF, 32'h01FFFFFF, ..., and wraps 32'hFFFFFFFF -> 32'h00FFFFFF.

Source files
------------

// File: rtl/currctrl_dbg_pkg.sv
// Shared types and constants for the current-control debug trace capture.
package currctrl_dbg_pkg;

  localparam int DBG_DEPTH  = 512;
  localparam int DBG_ADDR_W = 9;
  localparam int DBG_TS_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } dbg_state_e;

endpackage

// File: rtl/currctrl_dbg_decimator.sv
// Decimation counter for the trace capture: strobes accept on the first
// valid sample after clear, then on every (decim+1)th valid sample.
module currctrl_dbg_decimator (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] decim,
  input  logic       sample_valid,
  output logic       accept
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: reload on clear, otherwise step 0..decim on each valid sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (en && sample_valid) begin
      cnt_d = (cnt_q >= decim) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (!reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  assign accept = en && sample_valid && !clear && (cnt_q == 8'd0);

endmodule

// File: rtl/currctrl_debug_capture.sv
// Trace-capture writer for the current-control debug RAM (port 2).
// Decimated samples go into a circular pre/post-trigger buffer; on completion
// the buffer is frozen and start_addr points at the oldest sample.
// Optional: CURRCTRL_DBG_TIMESTAMP_EN replaces writedata2[31:24] with an
// 8-bit per-capture sample counter.
module currctrl_debug_capture
  import currctrl_dbg_pkg::*;
#(
  parameter int DEPTH  = DBG_DEPTH,
  parameter int ADDR_W = DBG_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [7:0]        decim,
  input  logic              trigger,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] address2,
  output logic [DATA_W-1:0] writedata2,
  output logic [3:0]        byteenable2,
  output logic              chipselect2,
  output logic              write2,
  output logic              clken2,
  output logic              busy,
  output logic              done,
  output logic              irq,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_CT = (ADDR_W+1)'(DEPTH);

  dbg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]        decim_q, decim_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] address2_q, address2_d;
  logic [DATA_W-1:0] writedata2_q, writedata2_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;

  logic              capturing;
  logic              arm_go;
  logic              accept_raw;
  logic              acc;
  logic              trig;
  logic              do_write;
  logic [ADDR_W-1:0] wr_ptr_nx;

`ifdef CURRCTRL_DBG_TIMESTAMP_EN
  logic [DBG_TS_W-1:0] ts_q, ts_d;
`endif

  assign capturing = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign acc       = accept_raw && !abort;
  assign trig      = trigger && !abort;
  assign wr_ptr_nx = wr_ptr_q + PTR_ONE;

  currctrl_dbg_decimator u_decim (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (arm_go),
    .en           (capturing),
    .decim        (decim_q),
    .sample_valid (sample_valid),
    .accept       (accept_raw)
  );

  // Capture FSM: next state, write pointer bookkeeping and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    decim_d      = decim_q;
    trig_addr_d  = trig_addr_q;
    post_cnt_d   = post_cnt_q;
    address2_d   = address2_q;
    writedata2_d = writedata2_q;
    start_addr_d = start_addr_q;
    write_d      = 1'b0;
    arm_go       = 1'b0;
    do_write     = 1'b0;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
    ts_d         = ts_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm && !abort) begin
          arm_go    = 1'b1;
          pre_cnt_d = pre_count;
          decim_d   = decim;
          wr_ptr_d  = '0;
          state_d   = (pre_count == '0) ? ST_ARMED : ST_PRE;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
          ts_d      = '0;
`endif
        end
      end
      ST_PRE: begin
        // Trigger is deliberately not looked at until the pre-trigger fill is complete.
        if (acc) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_nx;
          if (wr_ptr_nx == pre_cnt_q) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (acc) begin
          do_write = 1'b1;
          wr_ptr_d = wr_ptr_nx;
        end
        if (trig) begin
          // A sample written in the trigger cycle belongs to the pre-trigger window.
          trig_addr_d = wr_ptr_d;
          post_cnt_d  = DEPTH_CT - {1'b0, pre_cnt_q};
          state_d     = ST_POST;
        end
      end
      ST_POST: begin
        if (acc) begin
          do_write   = 1'b1;
          wr_ptr_d   = wr_ptr_nx;
          post_cnt_d = post_cnt_q - CNT_ONE;
          if (post_cnt_q == CNT_ONE) begin
            state_d      = ST_DONE;
            start_addr_d = trig_addr_q - pre_cnt_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;

    if (do_write) begin
      write_d    = 1'b1;
      address2_d = wr_ptr_q;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
      writedata2_d = {ts_q, sample_data[DATA_W-DBG_TS_W-1:0]};
      ts_d         = ts_q + 1'b1;
`else
      writedata2_d = sample_data;
`endif
    end

    busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
    irq_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      decim_q      <= '0;
      trig_addr_q  <= '0;
      post_cnt_q   <= '0;
      address2_q   <= '0;
      writedata2_q <= '0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      decim_q      <= decim_d;
      trig_addr_q  <= trig_addr_d;
      post_cnt_q   <= post_cnt_d;
      address2_q   <= address2_d;
      writedata2_q <= writedata2_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
      start_addr_q <= start_addr_d;
    end
  end

`ifdef CURRCTRL_DBG_TIMESTAMP_EN
  // Per-capture sample timestamp counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`endif

  assign address2    = address2_q;
  assign writedata2  = writedata2_q;
  assign byteenable2 = 4'hF;
  assign chipselect2 = write_q;
  assign write2      = write_q;
  assign clken2      = 1'b1;
  assign busy        = busy_q;
  assign done        = done_q;
  assign irq         = irq_q;
  assign start_addr  = start_addr_q;

endmodule

// File: tb/tb_currctrl_debug_capture.sv
// Directed self-checking bench for currctrl_debug_capture.
module tb_currctrl_debug_capture;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] pre_count = '0;
  logic [7:0]        decim = '0;
  logic              trigger = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic [ADDR_W-1:0] address2;
  logic [DATA_W-1:0] writedata2;
  logic [3:0]        byteenable2;
  logic              chipselect2;
  logic              write2;
  logic              clken2;
  logic              busy;
  logic              done;
  logic              irq;
  logic [ADDR_W-1:0] start_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int cs_bad = 0;
  int seq = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                wr_cyc[$];

  currctrl_debug_capture dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .abort        (abort),
    .pre_count    (pre_count),
    .decim        (decim),
    .trigger      (trigger),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .address2     (address2),
    .writedata2   (writedata2),
    .byteenable2  (byteenable2),
    .chipselect2  (chipselect2),
    .write2       (write2),
    .clken2       (clken2),
    .busy         (busy),
    .done         (done),
    .irq          (irq),
    .start_addr   (start_addr)
  );

  always #5 clk = ~clk;

  // Write/irq monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (write2) begin
      wr_addr.push_back(address2);
      wr_data.push_back(writedata2);
      wr_cyc.push_back(cyc);
    end
    if (chipselect2 !== write2) cs_bad++;
    if (irq) irq_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input int s, input int idx);
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
    logic [31:0] sv = s;
    logic [31:0] iv = idx;
    return {iv[7:0], sv[23:0]};
`else
    return s;
`endif
  endfunction

  // Advance to just after the falling edge (monitor has already sampled).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic arm_cfg(input int pre, input int dec, input logic trg);
    clear_log();
    pre_count    = ADDR_W'(pre);
    decim        = 8'(dec);
    trigger      = trg;
    sample_valid = 1'b0;
    arm          = 1'b1;
    tick();
    arm = 1'b0;
    seq = 0;
  endtask

  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = seq;
      tick();
      seq++;
    end
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed_until_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      sample_valid = 1'b1;
      sample_data  = seq;
      tick();
      seq++;
      n++;
    end
    sample_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Write i must land at address i mod 512 with the i-th accepted sample (i*step).
  task automatic check_log(input string tag, input int n, input int step);
    int bad = 0;
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < wr_addr.size() && i < n; i++) begin
      if (wr_addr[i] !== ADDR_W'(i % 512) || wr_data[i] !== exp_wd(i * step, i)) bad++;
    end
    check({tag, "_bad_words"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int irq0;
    int gap_bad;

    // Reset state.
    idle_cycles(3);
    check("rst_address2", 32'(address2), 32'd0);
    check("rst_writedata2", writedata2, 32'd0);
    check("rst_write2", 32'(write2), 32'd0);
    check("rst_chipselect2", 32'(chipselect2), 32'd0);
    check("rst_byteenable2", 32'(byteenable2), 32'hF);
    check("rst_clken2", 32'(clken2), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_start_addr", 32'(start_addr), 32'd0);
    reset_n = 1'b1;
    idle_cycles(2);

    // T1: pre=0, decim=0, trigger in cycle 5 before any sample, then continuous samples.
    irq0 = irq_cnt;
    arm_cfg(0, 0, 1'b0);
    check("t1_busy_armed", 32'(busy), 32'd1);
    idle_cycles(4);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    feed_until_done("t1", 700);
    check_log("t1", 512, 1);
    check("t1_irq_pulses", 32'(irq_cnt - irq0), 32'd1);
    check("t1_start_addr", 32'(start_addr), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd0);
    idle_cycles(3);
    check("t1_frozen_nwr", 32'(wr_addr.size()), 32'd512);
    check("t1_done_level", 32'(done), 32'd1);

    // T2: pre=100, trigger held from arm; arm during PRE must be ignored.
    irq0 = irq_cnt;
    arm_cfg(100, 0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      arm          = (i == 50);
      pre_count    = (i == 50) ? '0 : ADDR_W'(100);
      sample_valid = 1'b1;
      sample_data  = seq;
      tick();
      seq++;
    end
    arm = 1'b0;
    sample_valid = 1'b0;
    check("t2_pre_nwr", 32'(wr_addr.size()), 32'd100);
    check("t2_pre_busy", 32'(busy), 32'd1);
    check("t2_pre_not_done", 32'(done), 32'd0);
    idle_cycles(1);
    feed_until_done("t2", 700);
    trigger = 1'b0;
    check_log("t2", 512, 1);
    check("t2_start_addr", 32'(start_addr), 32'd0);
    check("t2_irq_pulses", 32'(irq_cnt - irq0), 32'd1);

    // T3: pre=100, trigger after 700 accepted samples (buffer wraps).
    irq0 = irq_cnt;
    arm_cfg(100, 0, 1'b0);
    drive_samples(700);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("t3_first_post_pending", 32'(wr_addr.size()), 32'd700);
    feed_until_done("t3", 700);
    check_log("t3", 1112, 1);
    check("t3_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd87);
    check("t3_start_addr", 32'(start_addr), 32'd88);
    check("t3_irq_pulses", 32'(irq_cnt - irq0), 32'd1);

    // T4: decim=3 with a valid sample every cycle.
    arm_cfg(0, 3, 1'b0);
    drive_samples(40);
    check_log("t4", 10, 4);
    gap_bad = 0;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 4) gap_bad++;
    check("t4_write_cadence", 32'(gap_bad), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_idle", 32'(busy), 32'd0);

    // T5: abort during POST, then re-arm.
    irq0 = irq_cnt;
    arm_cfg(0, 0, 1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    drive_samples(50);
    abort        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 32'hDEAD;
    tick();
    abort = 1'b0;
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    check("t5_nwr_at_abort", 32'(wr_addr.size()), 32'd50);
    drive_samples(5);
    check("t5_nwr_after_abort", 32'(wr_addr.size()), 32'd50);
    check("t5_no_irq", 32'(irq_cnt - irq0), 32'd0);
    check("t5_no_done", 32'(done), 32'd0);
    arm_cfg(0, 0, 1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    drive_samples(3);
    check_log("t5_rearm", 3, 1);

    // T6: reset mid-capture returns to IDLE.
    reset_n = 1'b0;
    tick();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_write2", 32'(write2), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    check("cs_matches_write", 32'(cs_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
